// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared types and encodings for the multicycle controller
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100
    } alu_op_t;

    localparam logic [1:0] TC_NONE    = 2'b00;
    localparam logic [1:0] TC_OVF     = 2'b01;
    localparam logic [1:0] TC_ILLEGAL = 2'b10;

    // Instructions whose second ALU operand is the sign-extended immediate.
    function automatic logic uses_imm(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/alu_control_decoder.sv
// rtl/alu_control_decoder.sv - maps (opcode, funct) to alu_op, illegal and overflow-check flags
//   opcode, funct : latched instruction fields
//   alu_op        : ALU operation for the EXEC cycle
//   illegal       : opcode unknown, or R-type with unsupported funct
//   ovf_checked   : signed overflow in EXEC must trap
module alu_control_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output alu_op_t    alu_op,
    output logic       illegal,
    output logic       ovf_checked
);

    always_comb begin
        alu_op      = ALU_ADD;
        illegal     = 1'b0;
        ovf_checked = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin alu_op = ALU_ADD; ovf_checked = 1'b1; end
                    FN_SUB: begin alu_op = ALU_SUB; ovf_checked = 1'b1; end
                    FN_AND: alu_op = ALU_AND;
                    FN_OR:  alu_op = ALU_OR;
                    FN_SLT: alu_op = ALU_SLT;
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin alu_op = ALU_ADD; ovf_checked = 1'b1; end
            OP_BEQ:  alu_op = ALU_SUB;
            OP_LW, OP_SW, OP_J, OP_HALT: alu_op = ALU_ADD;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// rtl/mips_multicycle_controller.sv - FETCH/DECODE/EXEC/MEM/WB sequencer driving datapath strobes
//   clk, clr (async, active high), run (stop at instruction boundary when low)
//   instr, F_zero, F_overflow : datapath inputs
//   ir_ld .. alu_op           : datapath control strobes
//   busy, halted, trap, trap_cause, retired : status
module mips_multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int ALU_OP_W = 3,
    parameter int COUNT_W  = 16
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                run,
    input  logic [31:0]         instr,
    input  logic                F_zero,
    input  logic                F_overflow,
    output logic                ir_ld,
    output logic                pc_inc,
    output logic                pc_ld,
    output logic                pc_sel,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                alu_src_b,
    output logic                mem_to_reg,
    output logic                dmu_wen,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                busy,
    output logic                halted,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [COUNT_W-1:0]  retired
);

    state_t             state, state_n;
    logic [5:0]         opcode_q, funct_q;
    logic [1:0]         trap_cause_q;
    logic [COUNT_W-1:0] retired_q;

    alu_op_t dec_alu_op;
    logic    dec_illegal, dec_ovf_checked;
    alu_op_t alu_op_int;
    logic    retire, set_ovf, set_ill;

    // Only the opcode and funct fields steer the sequencer.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[25:6];

    alu_control_decoder u_dec (
        .opcode      (opcode_q),
        .funct       (funct_q),
        .alu_op      (dec_alu_op),
        .illegal     (dec_illegal),
        .ovf_checked (dec_ovf_checked)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state        <= S_IDLE;
            opcode_q     <= '0;
            funct_q      <= '0;
            trap_cause_q <= TC_NONE;
            retired_q    <= '0;
        end else begin
            state <= state_n;
            if (state == S_FETCH) begin
                opcode_q <= instr[31:26];
                funct_q  <= instr[5:0];
            end
            if (set_ovf) begin
                trap_cause_q <= TC_OVF;
            end else if (set_ill) begin
                trap_cause_q <= TC_ILLEGAL;
            end
            if (retire) begin
                retired_q <= retired_q + COUNT_W'(1);
            end
        end
    end

    always_comb begin
        state_n    = state;
        ir_ld      = 1'b0;
        pc_inc     = 1'b0;
        pc_ld      = 1'b0;
        pc_sel     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        alu_src_b  = 1'b0;
        mem_to_reg = 1'b0;
        dmu_wen    = 1'b0;
        alu_op_int = ALU_ADD;
        retire     = 1'b0;
        set_ovf    = 1'b0;
        set_ill    = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) state_n = S_FETCH;
            end
            S_FETCH: begin
                ir_ld   = 1'b1;
                pc_inc  = 1'b1;
                state_n = S_DECODE;
            end
            S_DECODE: begin
                if (opcode_q == OP_J) begin
                    pc_ld  = 1'b1;
                    pc_sel = 1'b1;
                    retire = 1'b1;
                end else if (opcode_q == OP_HALT) begin
                    state_n = S_HALT;
                end else if (dec_illegal) begin
                    set_ill = 1'b1;
                    state_n = S_TRAP;
                end else begin
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_op_int = dec_alu_op;
                alu_src_b  = uses_imm(opcode_q);
                // Overflow aborts before any write-back or retire.
                if (dec_ovf_checked && F_overflow) begin
                    set_ovf = 1'b1;
                    state_n = S_TRAP;
                end else if (opcode_q == OP_BEQ) begin
                    pc_ld  = F_zero;
                    retire = 1'b1;
                end else if (opcode_q == OP_LW || opcode_q == OP_SW) begin
                    state_n = S_MEM;
                end else begin
                    state_n = S_WB;
                end
            end
            S_MEM: begin
                alu_op_int = ALU_ADD;
                alu_src_b  = 1'b1;
                if (opcode_q == OP_SW) begin
                    dmu_wen = 1'b1;
                    retire  = 1'b1;
                end else begin
                    state_n = S_WB;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (opcode_q == OP_RTYPE);
                mem_to_reg = (opcode_q == OP_LW);
                retire     = 1'b1;
            end
            S_HALT, S_TRAP: state_n = state;
            default: state_n = S_IDLE;
        endcase
        // run is only sampled at an instruction boundary.
        if (retire) state_n = run ? S_FETCH : S_IDLE;
    end

    assign alu_op     = ALU_OP_W'(alu_op_int);
    assign busy       = !(state == S_IDLE || state == S_HALT || state == S_TRAP);
    assign halted     = (state == S_HALT);
    assign trap       = (state == S_TRAP);
    assign trap_cause = trap_cause_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb/tb_mips_multicycle_controller.sv - table-driven bench for mips_multicycle_controller
module tb_mips_multicycle_controller;

    logic        clk = 1'b0;
    logic        clr, run, F_zero, F_overflow;
    logic [31:0] instr;
    logic        ir_ld, pc_inc, pc_ld, pc_sel, reg_write, reg_dst, alu_src_b, mem_to_reg, dmu_wen;
    logic [2:0]  alu_op;
    logic        busy, halted, trap;
    logic [1:0]  trap_cause;
    logic [15:0] retired;

    logic [8:0]  w2_unused_str;
    logic [2:0]  w2_unused_alu;
    logic [4:0]  w2_unused_st;
    logic [2:0]  w2_retired;

    always #5 clk = ~clk;

    mips_multicycle_controller dut (
        .clk(clk), .clr(clr), .run(run), .instr(instr), .F_zero(F_zero), .F_overflow(F_overflow),
        .ir_ld(ir_ld), .pc_inc(pc_inc), .pc_ld(pc_ld), .pc_sel(pc_sel), .reg_write(reg_write),
        .reg_dst(reg_dst), .alu_src_b(alu_src_b), .mem_to_reg(mem_to_reg), .dmu_wen(dmu_wen),
        .alu_op(alu_op), .busy(busy), .halted(halted), .trap(trap), .trap_cause(trap_cause),
        .retired(retired)
    );

    mips_multicycle_controller #(.ALU_OP_W(3), .COUNT_W(3)) dut_wrap (
        .clk(clk), .clr(clr), .run(run), .instr(instr), .F_zero(F_zero), .F_overflow(F_overflow),
        .ir_ld(w2_unused_str[8]), .pc_inc(w2_unused_str[7]), .pc_ld(w2_unused_str[6]),
        .pc_sel(w2_unused_str[5]), .reg_write(w2_unused_str[4]), .reg_dst(w2_unused_str[3]),
        .alu_src_b(w2_unused_str[2]), .mem_to_reg(w2_unused_str[1]), .dmu_wen(w2_unused_str[0]),
        .alu_op(w2_unused_alu), .busy(w2_unused_st[4]), .halted(w2_unused_st[3]),
        .trap(w2_unused_st[2]), .trap_cause(w2_unused_st[1:0]), .retired(w2_retired)
    );

    // {ir_ld,pc_inc,pc_ld,pc_sel,reg_write,reg_dst,alu_src_b,mem_to_reg,dmu_wen}
    localparam logic [8:0] S0    = 9'b000000000;
    localparam logic [8:0] SF    = 9'b110000000;
    localparam logic [8:0] SJ    = 9'b001100000;
    localparam logic [8:0] SBT   = 9'b001000000;
    localparam logic [8:0] SIMM  = 9'b000000100;
    localparam logic [8:0] SSW   = 9'b000000101;
    localparam logic [8:0] SWBR  = 9'b000011000;
    localparam logic [8:0] SWBL  = 9'b000010010;
    localparam logic [8:0] SWBI  = 9'b000010000;
    // {busy,halted,trap}
    localparam logic [2:0] STI = 3'b000, STB = 3'b100, STH = 3'b010, STT = 3'b001;

    localparam logic [31:0] I_ADD  = 32'h00221820, I_SUB = 32'h00221822;
    localparam logic [31:0] I_LW   = 32'h8C220004, I_SW  = 32'hAC220004;
    localparam logic [31:0] I_BEQ  = 32'h10220003, I_J   = 32'h08000010;
    localparam logic [31:0] I_ADDI = 32'h20220005, I_ILL = 32'hF8000000;
    localparam logic [31:0] I_BADF = 32'h00000000, I_HLT = 32'hFC000000;

    typedef struct {
        logic        clr_before;
        logic        run;
        logic [31:0] instr;
        logic        fz;
        logic        fo;
        logic [8:0]  str;
        logic [2:0]  alu;
        logic [2:0]  st;
        logic [1:0]  tc;
        logic [15:0] ret;
    } vec_t;

    vec_t tbl[0:79];
    int   n_vec = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic add(input logic cb, input logic r, input logic [31:0] i, input logic fz,
                       input logic fo, input logic [8:0] s, input logic [2:0] a,
                       input logic [2:0] st, input logic [1:0] tc, input logic [15:0] ret);
        tbl[n_vec] = '{cb, r, i, fz, fo, s, a, st, tc, ret};
        n_vec++;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] snap();
        return {ir_ld, pc_inc, pc_ld, pc_sel, reg_write, reg_dst, alu_src_b, mem_to_reg, dmu_wen,
                alu_op, busy, halted, trap, trap_cause, retired};
    endfunction

    initial begin
        clr = 1'b1; run = 1'b1; instr = I_ADD; F_zero = 1'b0; F_overflow = 1'b0;

        // ADD, LW, SW, BEQ taken/not taken, J, SUB, ADDI with run dropped in EXEC
        add(0,0,I_ADD,0,0,S0,  3'd0,STI,2'b00,16'd0);
        add(0,1,I_ADD,0,0,S0,  3'd0,STI,2'b00,16'd0);
        add(0,1,I_ADD,0,0,SF,  3'd0,STB,2'b00,16'd0);
        add(0,1,I_ADD,0,0,S0,  3'd0,STB,2'b00,16'd0);
        add(0,1,I_ADD,0,0,S0,  3'd0,STB,2'b00,16'd0);
        add(0,1,I_ADD,0,0,SWBR,3'd0,STB,2'b00,16'd0);
        add(0,1,I_LW, 0,0,SF,  3'd0,STB,2'b00,16'd1);
        add(0,1,I_LW, 0,0,S0,  3'd0,STB,2'b00,16'd1);
        add(0,1,I_LW, 0,0,SIMM,3'd0,STB,2'b00,16'd1);
        add(0,1,I_LW, 0,0,SIMM,3'd0,STB,2'b00,16'd1);
        add(0,1,I_LW, 0,0,SWBL,3'd0,STB,2'b00,16'd1);
        add(0,1,I_SW, 0,0,SF,  3'd0,STB,2'b00,16'd2);
        add(0,1,I_SW, 0,0,S0,  3'd0,STB,2'b00,16'd2);
        add(0,1,I_SW, 0,0,SIMM,3'd0,STB,2'b00,16'd2);
        add(0,1,I_SW, 0,0,SSW, 3'd0,STB,2'b00,16'd2);
        add(0,1,I_BEQ,1,0,SF,  3'd0,STB,2'b00,16'd3);
        add(0,1,I_BEQ,1,0,S0,  3'd0,STB,2'b00,16'd3);
        add(0,1,I_BEQ,1,0,SBT, 3'd1,STB,2'b00,16'd3);
        add(0,1,I_BEQ,0,0,SF,  3'd0,STB,2'b00,16'd4);
        add(0,1,I_BEQ,0,0,S0,  3'd0,STB,2'b00,16'd4);
        add(0,1,I_BEQ,0,0,S0,  3'd1,STB,2'b00,16'd4);
        add(0,1,I_J,  0,0,SF,  3'd0,STB,2'b00,16'd5);
        add(0,1,I_J,  0,0,SJ,  3'd0,STB,2'b00,16'd5);
        add(0,1,I_SUB,0,0,SF,  3'd0,STB,2'b00,16'd6);
        add(0,1,I_SUB,0,0,S0,  3'd0,STB,2'b00,16'd6);
        add(0,1,I_SUB,0,0,S0,  3'd1,STB,2'b00,16'd6);
        add(0,1,I_SUB,0,0,SWBR,3'd0,STB,2'b00,16'd6);
        add(0,1,I_ADDI,0,0,SF, 3'd0,STB,2'b00,16'd7);
        add(0,1,I_ADDI,0,0,S0, 3'd0,STB,2'b00,16'd7);
        add(0,0,I_ADDI,0,0,SIMM,3'd0,STB,2'b00,16'd7);
        add(0,0,I_ADDI,0,0,SWBI,3'd0,STB,2'b00,16'd7);
        add(0,0,I_ADDI,0,0,S0, 3'd0,STI,2'b00,16'd8);
        add(0,0,I_ADDI,0,0,S0, 3'd0,STI,2'b00,16'd8);
        // ADD overflow trap
        add(0,1,I_ADD,0,0,S0,  3'd0,STI,2'b00,16'd8);
        add(0,1,I_ADD,0,0,SF,  3'd0,STB,2'b00,16'd8);
        add(0,1,I_ADD,0,0,S0,  3'd0,STB,2'b00,16'd8);
        add(0,1,I_ADD,0,1,S0,  3'd0,STB,2'b00,16'd8);
        add(0,1,I_ADD,0,0,S0,  3'd0,STT,2'b01,16'd8);
        add(0,1,I_ADD,0,0,S0,  3'd0,STT,2'b01,16'd8);
        // illegal opcode 0x3E
        add(1,0,I_ILL,0,0,S0,  3'd0,STI,2'b00,16'd0);
        add(0,1,I_ILL,0,0,S0,  3'd0,STI,2'b00,16'd0);
        add(0,1,I_ILL,0,0,SF,  3'd0,STB,2'b00,16'd0);
        add(0,1,I_ILL,0,0,S0,  3'd0,STB,2'b00,16'd0);
        add(0,1,I_ILL,0,0,S0,  3'd0,STT,2'b10,16'd0);
        // R-type with unsupported funct
        add(1,1,I_BADF,0,0,S0, 3'd0,STI,2'b00,16'd0);
        add(0,1,I_BADF,0,0,SF, 3'd0,STB,2'b00,16'd0);
        add(0,1,I_BADF,0,0,S0, 3'd0,STB,2'b00,16'd0);
        add(0,1,I_BADF,0,0,S0, 3'd0,STT,2'b10,16'd0);
        // HALT
        add(1,1,I_HLT,0,0,S0,  3'd0,STI,2'b00,16'd0);
        add(0,1,I_HLT,0,0,SF,  3'd0,STB,2'b00,16'd0);
        add(0,1,I_HLT,0,0,S0,  3'd0,STB,2'b00,16'd0);
        add(0,1,I_HLT,0,0,S0,  3'd0,STH,2'b00,16'd0);
        add(0,1,I_HLT,0,0,S0,  3'd0,STH,2'b00,16'd0);

        // reset state while clr held with run=1
        #12;
        check("reset_state", 64'(snap()), 64'(33'd0));
        @(negedge clk);
        clr = 1'b0; run = 1'b0;

        for (int i = 0; i < n_vec; i++) begin
            @(negedge clk);
            if (tbl[i].clr_before) begin
                clr = 1'b1; #1; clr = 1'b0;
            end
            run = tbl[i].run; instr = tbl[i].instr;
            F_zero = tbl[i].fz; F_overflow = tbl[i].fo;
            #1;
            check($sformatf("vec%0d", i), 64'(snap()),
                  64'({tbl[i].str, tbl[i].alu, tbl[i].st, tbl[i].tc, tbl[i].ret}));
        end

        // clr asserted during MEM of SW
        @(negedge clk);
        clr = 1'b1; #1; clr = 1'b0;
        run = 1'b1; instr = I_SW; F_zero = 1'b0; F_overflow = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("sw_mem_wen", 64'({dmu_wen, busy}), 64'(2'b11));
        #1 clr = 1'b1;
        #1;
        check("clr_mid_mem", 64'(snap()), 64'(33'd0));
        run = 1'b0;
        #1 clr = 1'b0;
        @(negedge clk); #1;
        check("after_clr_idle", 64'(snap()), 64'(33'd0));

        // counter wrap on the narrow-counter instance, back-to-back J
        @(negedge clk);
        clr = 1'b1; #1; clr = 1'b0;
        run = 1'b1; instr = I_J;
        for (int p = 1; p <= 17; p++) begin
            @(negedge clk);
            if (p == 15) begin
                #1 check("wrap_pre", 64'(w2_retired), 64'(3'd7));
            end
        end
        #1;
        check("wrap_zero", 64'(w2_retired), 64'(3'd0));
        check("wide_count", 64'(retired), 64'(16'd8));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
